// File: rtl/hash_query_ctrl_pkg.sv
// Shared query and FSM types for the hash query controller and its table.
// Defining HASH_QUERY_CTRL_CLEAR_EN adds the CLEAR state that zeroes the table after reset.
package hash_table_pkg;

  typedef enum logic {
    INSERT_QUERY  = 1'b0,
    LOOK_UP_QUERY = 1'b1
  } hash_query_t;

`ifdef HASH_QUERY_CTRL_CLEAR_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WRITE = 2'd2,
    CLEAR = 2'd3
  } hq_state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WRITE = 2'd2
  } hq_state_t;
`endif

endpackage

// File: rtl/hash_query_ctrl_if.sv
// Request/result bundle between a requester (master) and hash_query_ctrl (slave).
// Ready is asserted by the controller only when it can take a query.
interface hash_query_ctrl_if #(
  parameter int KEY_W = 12,
  parameter int VAL_W = 32
);
  import hash_table_pkg::*;

  logic             ins_valid;
  logic             ins_ready;
  logic [KEY_W-1:0] ins_key;
  logic [VAL_W-1:0] ins_val;
  logic             lkp_valid;
  logic             lkp_ready;
  logic [KEY_W-1:0] lkp_key;
  logic [VAL_W-1:0] lkp_val;
  logic             res_valid;
  hash_query_t      res_query;
  logic             res_ok;
  logic             init_done;

  modport master (
    output ins_valid, ins_key, ins_val, lkp_valid, lkp_key, lkp_val,
    input  ins_ready, lkp_ready, res_valid, res_query, res_ok, init_done
  );

  modport slave (
    input  ins_valid, ins_key, ins_val, lkp_valid, lkp_key, lkp_val,
    output ins_ready, lkp_ready, res_valid, res_query, res_ok, init_done
  );
endinterface

// File: rtl/hash_query_ctrl_table.sv
// Direct-mapped value table: read registered on rd_en, resp valid the next cycle.
// resp = slot empty (insert) or stored == cmp_val (lookup); no backpressure, one write port.
module hash_table
  import hash_table_pkg::*;
#(
  parameter int KEY_W = 12,
  parameter int VAL_W = 32
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [KEY_W-1:0] rd_key,
  input  hash_query_t      rd_query,
  input  logic [VAL_W-1:0] cmp_val,
  output logic             resp,
  input  logic             wr_en,
  input  logic [KEY_W-1:0] wr_key,
  input  logic [VAL_W-1:0] wr_val
);

  logic [VAL_W-1:0] mem [2**KEY_W];
  logic [VAL_W-1:0] rd_dat;
  hash_query_t      rd_query_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_key] <= wr_val;
    end
    if (rd_en) begin
      rd_dat     <= mem[rd_key];
      rd_query_q <= rd_query;
    end
  end

  // cmp_val comes from the controller's registered request, aligned with rd_dat.
  assign resp = (rd_query_q == INSERT_QUERY) ? (rd_dat == '0) : (rd_dat == cmp_val);

endmodule

// File: rtl/hash_query_ctrl.sv
// Insert/lookup controller over hash_table; lookup/rejected insert 1 cycle, insert 2 cycles.
// Single query in flight: both readies low outside IDLE, round-robin on ties; optional HASH_QUERY_CTRL_CLEAR_EN.
module hash_query_ctrl
  import hash_table_pkg::*;
#(
  parameter int KEY_W = 12,
  parameter int VAL_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  hash_query_ctrl_if.slave bus
);

  hq_state_t        state, state_nxt;
  logic             tie_to_lkp;
  logic             init_done;
  logic             idle_open;
  logic             grant_ins, grant_lkp, accept;
  logic [KEY_W-1:0] rd_key;
  hash_query_t      rd_query;
  logic [KEY_W-1:0] key_q;
  logic [VAL_W-1:0] val_q;
  hash_query_t      query_q;
  logic             resp;
  logic             res_valid_c, res_ok_c, wr_en_c;
  hash_query_t      res_query_c;
  logic [KEY_W-1:0] wr_key_c;
  logic [VAL_W-1:0] wr_val_c;
  logic             wr_en;

`ifdef HASH_QUERY_CTRL_CLEAR_EN
  logic [KEY_W-1:0] clr_addr;
  assign init_done = !rst && (state != CLEAR);
`else
  assign init_done = !rst;
`endif

  assign idle_open = (state == IDLE) && init_done;
  assign grant_ins = idle_open && bus.ins_valid && (!bus.lkp_valid || !tie_to_lkp);
  assign grant_lkp = idle_open && bus.lkp_valid && !grant_ins;
  assign accept    = grant_ins || grant_lkp;
  assign rd_key    = grant_lkp ? bus.lkp_key : bus.ins_key;
  assign rd_query  = grant_lkp ? LOOK_UP_QUERY : INSERT_QUERY;

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef HASH_QUERY_CTRL_CLEAR_EN
      state    <= CLEAR;
      clr_addr <= '0;
`else
      state    <= IDLE;
`endif
      tie_to_lkp <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        tie_to_lkp <= grant_ins;
      end
`ifdef HASH_QUERY_CTRL_CLEAR_EN
      if (state == CLEAR) begin
        clr_addr <= clr_addr + KEY_W'(1);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      key_q   <= rd_key;
      val_q   <= grant_lkp ? bus.lkp_val : bus.ins_val;
      query_q <= rd_query;
    end
  end

  always_comb begin
    state_nxt   = state;
    res_valid_c = 1'b0;
    res_ok_c    = 1'b0;
    res_query_c = INSERT_QUERY;
    wr_en_c     = 1'b0;
    wr_key_c    = key_q;
    wr_val_c    = val_q;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (query_q == LOOK_UP_QUERY) begin
          res_valid_c = 1'b1;
          res_query_c = LOOK_UP_QUERY;
          res_ok_c    = resp;
          state_nxt   = IDLE;
        end else if (resp && (val_q != '0)) begin
          state_nxt = WRITE;
        end else begin
          res_valid_c = 1'b1;
          state_nxt   = IDLE;
        end
      end
      WRITE: begin
        wr_en_c     = 1'b1;
        res_valid_c = 1'b1;
        res_ok_c    = 1'b1;
        state_nxt   = IDLE;
      end
`ifdef HASH_QUERY_CTRL_CLEAR_EN
      CLEAR: begin
        wr_en_c  = 1'b1;
        wr_key_c = clr_addr;
        wr_val_c = '0;
        if (clr_addr == '1) begin
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Reset masks every strobe so a query caught in CHECK/WRITE leaves no trace.
  assign wr_en         = wr_en_c && !rst;
  assign bus.ins_ready = grant_ins;
  assign bus.lkp_ready = grant_lkp;
  assign bus.res_valid = res_valid_c && !rst;
  assign bus.res_ok    = res_ok_c && !rst;
  assign bus.res_query = rst ? INSERT_QUERY : res_query_c;
  assign bus.init_done = init_done;

  hash_table #(
    .KEY_W (KEY_W),
    .VAL_W (VAL_W)
  ) u_table (
    .clk      (clk),
    .rd_en    (accept),
    .rd_key   (rd_key),
    .rd_query (rd_query),
    .cmp_val  (val_q),
    .resp     (resp),
    .wr_en    (wr_en),
    .wr_key   (wr_key_c),
    .wr_val   (wr_val_c)
  );

endmodule

// File: tb/tb_hash_query_ctrl.sv
// Scoreboard bench for hash_query_ctrl: a value-table model predicts each result, latency and write strobe.
module tb_hash_query_ctrl;
  import hash_table_pkg::*;

`ifdef HASH_QUERY_CTRL_CLEAR_EN
  localparam int CLR_CYC = 4096;
`else
  localparam int CLR_CYC = 0;
`endif

  typedef struct {
    int          cyc;
    hash_query_t q;
    bit          ok;
    bit          wr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_bad = 0;
  bit          tie_to_lkp = 1'b0;
  bit          inflight = 1'b0;
  logic [31:0] model [4096];
  exp_t        sb [$];

  hash_query_ctrl_if #(.KEY_W(12), .VAL_W(32)) bus ();

  hash_query_ctrl #(.KEY_W(12), .VAL_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input bit lk, input logic [11:0] k, input logic [31:0] v);
    exp_t e;
    if (lk) begin
      e.q   = LOOK_UP_QUERY;
      e.ok  = (model[k] == v);
      e.wr  = 1'b0;
      e.cyc = cyc + 1;
    end else begin
      e.q   = INSERT_QUERY;
      e.ok  = (model[k] == 32'h0) && (v != 32'h0);
      e.wr  = e.ok;
      e.cyc = cyc + (e.ok ? 2 : 1);
      if (e.ok) model[k] = v;
    end
    tie_to_lkp = !lk;
    sb.push_back(e);
  endtask

  task automatic send(input bit lk, input logic [11:0] k, input logic [31:0] v, input bit track);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    @(posedge clk); #1;
    if (lk) begin
      bus.lkp_valid = 1'b1; bus.lkp_key = k; bus.lkp_val = v;
    end else begin
      bus.ins_valid = 1'b1; bus.ins_key = k; bus.ins_val = v;
    end
    while (!done && n < 200) begin
      @(negedge clk);
      if (lk ? bus.lkp_ready : bus.ins_ready) begin
        done = 1'b1;
        if (track) push_exp(lk, k, v);
        else tie_to_lkp = !lk;
      end else begin
        n++;
      end
    end
    if (!done) chk("rdy_timeout", 0, 1);
    @(posedge clk); #1;
    bus.ins_valid = 1'b0;
    bus.lkp_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.init_done && n < 5000) begin
      n++;
      @(negedge clk);
    end
    chk(tag, n, CLR_CYC);
  endtask

  // Both requesters held valid for 12 cycles; grants must alternate.
  task automatic rr_burst(input logic [11:0] ibase);
    logic [11:0] ik;
    logic [31:0] iv;
    int grants;
    bit gi, gl;
    ik = ibase;
    iv = 32'h100;
    grants = 0;
    @(posedge clk); #1;
    bus.ins_key = ik; bus.ins_val = iv;
    bus.lkp_key = 12'h010; bus.lkp_val = 32'hDEADBEEF;
    bus.ins_valid = 1'b1; bus.lkp_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      gi = bus.ins_ready;
      gl = bus.lkp_ready;
      if (gi || gl) begin
        chk("rr_one_ready", gi && gl, 0);
        chk("rr_turn", gl, tie_to_lkp);
        grants++;
        if (gl) push_exp(1'b1, 12'h010, 32'hDEADBEEF);
        else push_exp(1'b0, ik, iv);
      end
      @(posedge clk); #1;
      if (gi) begin
        ik = ik + 12'h1;
        iv = iv + 32'h1;
        bus.ins_key = ik;
        bus.ins_val = iv;
      end
    end
    bus.ins_valid = 1'b0;
    bus.lkp_valid = 1'b0;
    chk("rr_grants", grants, 5);
    drain();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.res_valid || dut.wr_en) chk("rst_quiet", {bus.res_valid, dut.wr_en}, 0);
        inflight = 1'b0;
      end else begin
        if ((bus.ins_ready || bus.lkp_ready) && inflight) chk("ready_busy", 1, 0);
        if ((bus.ins_valid && bus.ins_ready) || (bus.lkp_valid && bus.lkp_ready)) inflight = 1'b1;
        if (sb.size() != 0 && sb[0].cyc < cyc) begin
          chk("res_late", cyc, sb[0].cyc);
          sb.delete(0);
        end
        if (bus.res_valid) begin
          inflight = 1'b0;
          if (sb.size() == 0) begin
            chk("res_spurious", 1, 0);
          end else begin
            chk("res_cyc", cyc, sb[0].cyc);
            chk("res_query", bus.res_query, sb[0].q);
            chk("res_ok", bus.res_ok, sb[0].ok);
            chk("wr_en", dut.wr_en, sb[0].wr);
            sb.delete(0);
          end
        end else begin
          if (dut.wr_en && bus.init_done) chk("stray_wr", 1, 0);
          if (bus.res_query != INSERT_QUERY || bus.res_ok) chk("idle_quiet", {bus.res_query, bus.res_ok}, 0);
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) model[i] = 32'h0;
    bus.ins_valid = 1'b0; bus.ins_key = '0; bus.ins_val = '0;
    bus.lkp_valid = 1'b0; bus.lkp_key = '0; bus.lkp_val = '0;

    repeat (2) @(posedge clk);
    bus.ins_valid = 1'b1;
    bus.lkp_valid = 1'b1;
    @(negedge clk);
    chk("rst_ins_ready", bus.ins_ready, 0);
    chk("rst_lkp_ready", bus.lkp_ready, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_ok", bus.res_ok, 0);
    chk("rst_res_query", bus.res_query, INSERT_QUERY);
    chk("rst_init_done", bus.init_done, 0);
    bus.ins_valid = 1'b0;
    bus.lkp_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_init("init_cycles");

    send(1'b1, 12'h123, 32'h0, 1'b1);
    drain();
    send(1'b0, 12'h010, 32'hDEADBEEF, 1'b1);
    drain();
    send(1'b1, 12'h010, 32'hDEADBEEF, 1'b1);
    send(1'b1, 12'h010, 32'h1, 1'b1);
    drain();
    send(1'b0, 12'h010, 32'h5, 1'b1);
    send(1'b1, 12'h010, 32'hDEADBEEF, 1'b1);
    drain();
    send(1'b0, 12'h020, 32'h0, 1'b1);
    send(1'b1, 12'h020, 32'h0, 1'b1);
    drain();
    send(1'b0, 12'h030, 32'h77, 1'b1);
    send(1'b1, 12'h030, 32'h77, 1'b1);
    drain();
    rr_burst(12'h300);

    // Reset lands in CHECK of an insert that would have succeeded.
    send(1'b0, 12'h200, 32'h7, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tie_to_lkp = 1'b0;
`ifdef HASH_QUERY_CTRL_CLEAR_EN
    for (int i = 0; i < 4096; i++) model[i] = 32'h0;
`endif
    wait_init("init_cycles_abort");
    rr_burst(12'h400);
    send(1'b1, 12'h200, 32'h0, 1'b1);
    drain();

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
